frame_serializer: RTL
=====================

# frame_serializer

Transmit-side serializer for the self-test serial link. It accepts a parallel word over a valid/ready handshake and emits it on a single wire as a framed bit stream: a two-bit `11` sync preamble, then the data bits MSB first, then a forced-low idle gap. It sits directly upstream of the link deserializer, which hunts for the `11` preamble and then shifts in the payload.

## Interface
- `DATA_W`, 32: payload width in bits. Legal range is 8..32.
- `IDLE_GAP`, 2: minimum number of low cycles driven after each frame. Legal range is 1..15.

- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_data`  in  DATA_W: word to transmit; sampled on the handshake edge.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a word; registered.
- `data_out`  out  1: serial line; registered; idles low.
- `busy`  out  1: high from the cycle after acceptance through the last gap cycle.
- `frame_done`  out  1: one-cycle pulse coincident with the final payload (or parity) bit on `data_out`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `data_out`=0.
  - SYNC: 2 cycles, `data_out`=1.
  - DATA: DATA_W cycles.
  - PAR: 1 cycle; exists only with the macro.
  - GAP: IDLE_GAP cycles, `data_out`=0.
  - Transitions: IDLE→SYNC on `in_valid & in_ready`; SYNC→DATA after 2 cycles; DATA→(PAR|GAP) after DATA_W bits; PAR→GAP; GAP→IDLE.
- Handshake:
  - A transfer occurs on the edge where `in_valid` and `in_ready` are both 1. `in_data` is copied into the DATA_W-bit shift register on that edge.
  - `in_ready` drops on that same edge. `in_valid` while `in_ready`=0 is ignored, and `in_data` may change freely then.
- Shifting: in DATA, `data_out` = shift_reg[DATA_W-1]; the register shifts left one bit per cycle with 0 filled in.
- Bit counter: 5 bits, counts 0..DATA_W-1 in DATA and 0..IDLE_GAP-1 in GAP, and is cleared on each state entry. There is no wrap-around beyond these terminal values.
- Payload constraint: none. A payload starting `11…` is legal because the downstream stage is locked once the preamble is seen.
- Reset:
  - Asserting `rst_n` mid-frame immediately forces `data_out`=0, `in_ready`=0, `busy`=0, `frame_done`=0 and FSM=IDLE. The in-flight word is discarded, and no partial frame resumes.
  - `in_ready` rises at the first `clk` edge after `rst_n` deasserts.

## Timing
- Reset values: `data_out`=0, `in_ready`=0, `busy`=0, `frame_done`=0, shift register=0, counter=0.
- Handshake at edge T gives:
  - `data_out`=1 during cycles T+1 and T+2.
  - Payload bit DATA_W-1 in cycle T+3, through bit 0 in cycle T+2+DATA_W.
  - `frame_done`=1 in cycle T+2+DATA_W without the macro, or T+3+DATA_W with it.
- GAP occupies the IDLE_GAP cycles after the last bit. `in_ready` returns to 1 in the cycle after GAP ends.
- Earliest next handshake: the frame period is 2+DATA_W+IDLE_GAP+1 cycles without the macro, plus 1 with it. With defaults and no macro this is 37 cycles.
- Back-to-back words therefore always have at least IDLE_GAP low cycles between frames. This returns the downstream deserializer to its hunt state.

## Configuration
- `FRAME_SERIALIZER_PARITY_EN`
  - Defined: the PAR state is compiled in. It appends one even-parity bit, the XOR of all DATA_W payload bits, immediately after bit 0. `frame_done` moves to the PAR cycle.
  - Undefined: no PAR state and no parity logic. GAP follows bit 0 directly.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=0xA5A50F0F → `in_ready` rises 1 cycle after reset release. `data_out` shows `11`, then 1010 0101 1010 0101 0000 1111 0000 1111, then 2 zeros. `frame_done` is high with the final `1`.
- `in_valid` held high with words 0xFFFFFFFF then 0x00000001 → two frames, each starting with `11`. Exactly 2 low cycles plus 1 IDLE cycle separate the last bit of frame 1 from the first sync bit of frame 2. The handshake period is 37 cycles.
- Pulse `in_valid` with 0x12345678 during DATA of an in-flight frame → the word is ignored, and the current frame's bits are unchanged.
- Assert `rst_n` low for 1 cycle at payload bit 10 of 0xDEADBEEF → `data_out`=0 immediately. No further frame bits appear, and `in_ready`=1 one edge after release.
- With the macro and DATA_W=32: 0x00000001 → parity bit 1 follows the LSB and `frame_done` pulses on it. 0x00000003 → parity bit 0.
- IDLE_GAP=5, DATA_W=8, `in_data`=0x81 → the frame is `11` `10000001` then 5 low cycles. `busy` stays high for 15 cycles.

Source files
------------

// File: rtl/frame_serializer.sv
// Framed serial transmitter: "11" preamble, DATA_W payload bits MSB first, forced-low idle gap.
// Optional even-parity bit after the LSB when FRAME_SERIALIZER_PARITY_EN is defined.
module frame_serializer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
        S_GAP  = 3'd3
`ifdef FRAME_SERIALIZER_PARITY_EN
        ,
        S_PAR  = 3'd4
`endif
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [DATA_W-1:0]  shift_reg;
    logic               accept;
    logic               in_ready_d;
    logic               data_out_d;
    logic               busy_d;
    logic               frame_done_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
    logic               par_bit;
`endif

    assign accept = (state == S_IDLE) && in_valid && in_ready;

    // State and per-state cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state; the counter restarts on every state entry and rests at zero in IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid && in_ready) state_next = S_SYNC;
            S_SYNC: if (cnt == SYNC_LAST)     state_next = S_DATA;
            S_DATA: begin
                if (cnt == DATA_LAST) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
                    state_next = S_PAR;
`else
                    state_next = S_GAP;
`endif
                end
            end
`ifdef FRAME_SERIALIZER_PARITY_EN
            S_PAR:  state_next = S_GAP;
`endif
            S_GAP:  if (cnt == GAP_LAST)      state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if ((state_next != state) || (state == S_IDLE)) cnt_next = '0;
        else                                              cnt_next = cnt + CNT_W'(1);
    end

    // Output values for the upcoming cycle, derived from the state being entered
    always_comb begin
        in_ready_d   = (state_next == S_IDLE);
        busy_d       = (state_next != S_IDLE);
        data_out_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_next)
            S_SYNC: data_out_d = 1'b1;
            S_DATA: begin
                data_out_d = shift_reg[DATA_W-1];
`ifndef FRAME_SERIALIZER_PARITY_EN
                frame_done_d = (cnt_next == DATA_LAST);
`endif
            end
`ifdef FRAME_SERIALIZER_PARITY_EN
            S_PAR: begin
                data_out_d   = par_bit;
                frame_done_d = 1'b1;
            end
`endif
            default: data_out_d = 1'b0;
        endcase
    end

    // Registered outputs and payload shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            data_out   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shift_reg  <= '0;
        end else begin
            in_ready   <= in_ready_d;
            data_out   <= data_out_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            if (accept)                   shift_reg <= in_data;
            else if (state_next == S_DATA) shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        end
    end

`ifdef FRAME_SERIALIZER_PARITY_EN
    // Even parity of the whole payload, captured with the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      par_bit <= 1'b0;
        else if (accept) par_bit <= ^in_data;
    end
`endif

endmodule
